// File: rtl/esc_pkg.sv
// esc_pkg: throttle/width sizing, PWM range constants shared with the ESC core,
// capture FSM states and the width-to-throttle mapping.
package esc_pkg;

    localparam int unsigned THR_W            = 10;
    localparam int unsigned WIDTH_W          = 12;

    localparam int unsigned TICKS_PER_US_DEF = 10;
    localparam int unsigned TIMEOUT_US_DEF   = 25000;
    localparam int unsigned MIN_US           = 1000;
    localparam int unsigned MAX_US           = 2000;
    localparam int unsigned GUARD_US         = 100;
    localparam int unsigned ARM_THR          = 20;
    localparam int unsigned ARM_CNT          = 4;
    localparam int unsigned FILT_CYC         = 4;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } cap_state_e;

    // Clamp an accepted width into [MIN_US,MAX_US] and offset it to a 0-based throttle.
    function automatic logic [THR_W-1:0] width_to_thr(input logic [WIDTH_W-1:0] i_w);
        logic [WIDTH_W-1:0] w_c;
        if (i_w < WIDTH_W'(MIN_US)) begin
            w_c = WIDTH_W'(MIN_US);
        end else if (i_w > WIDTH_W'(MAX_US)) begin
            w_c = WIDTH_W'(MAX_US);
        end else begin
            w_c = i_w;
        end
        width_to_thr = THR_W'(w_c - WIDTH_W'(MIN_US));
    endfunction

endpackage

// File: rtl/esc_sync_filter.sv
// esc_sync_filter: 2-FF synchronizer for the PWM pad, plus an optional stability filter
// enabled by ESC_CAP_FILTER_EN.
module esc_sync_filter
    import esc_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pad,
    output logic o_lvl
);
    logic [1:0] r_sync;

    // Reset to high so a pulse already in progress at reset release cannot look like a fresh low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_pad};
        end
    end

`ifdef ESC_CAP_FILTER_EN
    localparam int unsigned CNT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    logic [CNT_W-1:0] r_stab;
    logic             r_lvl;

    // Adopt a new level only after it has persisted for FILT_CYC clocks; same delay on both edges
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lvl  <= 1'b1;
            r_stab <= '0;
        end else if (r_sync[1] == r_lvl) begin
            r_stab <= '0;
        end else if (r_stab == CNT_W'(FILT_CYC - 1)) begin
            r_lvl  <= r_sync[1];
            r_stab <= '0;
        end else begin
            r_stab <= r_stab + 1'b1;
        end
    end

    assign o_lvl = r_lvl;
`else
    assign o_lvl = r_sync[1];
`endif

endmodule

// File: rtl/esc_pwm_capture.sv
// esc_pwm_capture: decodes an RC servo PWM pulse into a validated throttle command with arming
// and signal-loss failsafe. Optional pad glitch filter: define ESC_CAP_FILTER_EN.
module esc_pwm_capture
    import esc_pkg::*;
#(
    parameter int unsigned TICKS_PER_US = TICKS_PER_US_DEF,
    parameter int unsigned TIMEOUT_US   = TIMEOUT_US_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             pwm_i,
    output logic [THR_W-1:0] thr_o,
    output logic             thr_valid_o,
    output logic             armed_o,
    output logic             failsafe_o,
    output logic             pulse_err_o
);
    localparam int unsigned PRESC_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_US + 1);
    localparam int unsigned ARM_W   = $clog2(ARM_CNT + 1);

    logic               w_lvl;
    logic               w_rise;
    logic               w_fall;
    logic               w_tick;
    logic               w_eval;
    logic               w_too_long;
    logic               w_in_band;
    logic               w_accept;
    logic               w_reject;
    logic               w_to_hit;
    logic [THR_W-1:0]   w_thr;
    cap_state_e         w_state_nxt;

    logic               r_lvl_d;
    logic [PRESC_W-1:0] r_presc;
    logic [WIDTH_W-1:0] r_width;
    logic [TO_W-1:0]    r_to_cnt;
    logic [ARM_W-1:0]   r_arm_cnt;
    cap_state_e         r_state;

    esc_sync_filter u_sync (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_pad   (pwm_i),
        .o_lvl   (w_lvl)
    );

    assign w_rise    = w_lvl & ~r_lvl_d;
    assign w_fall    = ~w_lvl & r_lvl_d;
    assign w_tick    = (r_presc == PRESC_W'(TICKS_PER_US - 1));
    assign w_in_band = (r_width >= WIDTH_W'(MIN_US - GUARD_US)) &&
                       (r_width <= WIDTH_W'(MAX_US + GUARD_US));
    assign w_accept  = w_eval & w_in_band;
    assign w_reject  = (w_eval & ~w_in_band) | w_too_long;
    assign w_thr     = width_to_thr(r_width);
    assign w_to_hit  = w_tick && (r_to_cnt == TO_W'(TIMEOUT_US - 1));

    // Delayed clean level for edge detection
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_lvl_d <= 1'b1;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    // Microsecond prescaler; the rising-edge cycle counts as the first clock of the pulse
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_presc <= '0;
        end else if (w_rise) begin
            r_presc <= PRESC_W'(1);
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Capture FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM next state and evaluate/abort decisions
    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        w_too_long  = 1'b0;
        case (r_state)
            WAIT_LOW: begin
                if (!w_lvl) begin
                    w_state_nxt = WAIT_RISE;
                end else begin
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                end else begin
                    w_state_nxt = WAIT_RISE;
                end
            end
            MEASURE: begin
                if (w_fall) begin
                    w_eval      = 1'b1;
                    w_state_nxt = WAIT_RISE;
                end else if (r_width > WIDTH_W'(MAX_US + GUARD_US)) begin
                    w_too_long  = 1'b1;
                    w_state_nxt = WAIT_LOW;
                end else begin
                    w_state_nxt = MEASURE;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOW;
            end
        endcase
    end

    // Pulse width in microseconds, saturating at the register maximum
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_width <= '0;
        end else if ((r_state == WAIT_RISE) && w_rise) begin
            r_width <= '0;
        end else if ((r_state == MEASURE) && w_tick && (r_width != {WIDTH_W{1'b1}})) begin
            r_width <= r_width + 1'b1;
        end
    end

    // Signal-loss timer in microseconds; holds once it has expired
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (w_tick && (r_to_cnt != TO_W'(TIMEOUT_US))) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Throttle output, arming and failsafe; an accepted pulse outranks a timeout in the same cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            thr_o       <= '0;
            thr_valid_o <= 1'b0;
            armed_o     <= 1'b0;
            failsafe_o  <= 1'b1;
            pulse_err_o <= 1'b0;
            r_arm_cnt   <= '0;
        end else begin
            thr_valid_o <= w_accept;
            pulse_err_o <= w_reject;
            if (w_accept) begin
                failsafe_o <= 1'b0;
                if (armed_o) begin
                    thr_o <= w_thr;
                end else begin
                    thr_o <= '0;
                    if (w_thr <= THR_W'(ARM_THR)) begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                        if (r_arm_cnt == ARM_W'(ARM_CNT - 1)) begin
                            armed_o <= 1'b1;
                        end
                    end else begin
                        r_arm_cnt <= '0;
                    end
                end
            end else if (w_to_hit) begin
                failsafe_o <= 1'b1;
                armed_o    <= 1'b0;
                thr_o      <= '0;
                r_arm_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_esc_pwm_capture.sv
// tb_esc_pwm_capture: randomized pulse stimulus against a pulse-level reference model of
// throttle mapping, arming, failsafe and error reporting (runs with a scaled-down clock/timeout).
module tb_esc_pwm_capture;

    localparam int T        = 2;
    localparam int TO_US    = 4500;
    localparam int MIN_US   = 1000;
    localparam int MAX_US   = 2000;
    localparam int GUARD_US = 100;
    localparam int ARM_THR  = 20;
    localparam int ARM_CNT  = 4;
`ifdef ESC_CAP_FILTER_EN
    localparam int LAT        = 3 + 4;
    localparam int GLITCH_ERR = 0;
`else
    localparam int LAT        = 3;
    localparam int GLITCH_ERR = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm;
    logic [9:0] thr;
    logic       thr_valid;
    logic       armed;
    logic       failsafe;
    logic       perr;

    esc_pwm_capture #(.TICKS_PER_US(T), .TIMEOUT_US(TO_US)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .pwm_i       (pwm),
        .thr_o       (thr),
        .thr_valid_o (thr_valid),
        .armed_o     (armed),
        .failsafe_o  (failsafe),
        .pulse_err_o (perr)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge
    int         cyc = 0;
    int         n_strb = 0;
    int         n_perr = 0;
    int         n_fsrise = 0;
    int         strb_cyc = 0;
    int         fsrise_cyc = 0;
    logic [9:0] strb_thr = '0;
    logic       strb_armed = 1'b0;
    logic       strb_fs = 1'b0;
    logic       fs_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (thr_valid) begin
            n_strb     <= n_strb + 1;
            strb_cyc   <= cyc;
            strb_thr   <= thr;
            strb_armed <= armed;
            strb_fs    <= failsafe;
        end
        if (perr) n_perr <= n_perr + 1;
        if (failsafe && !fs_prev) begin
            n_fsrise   <= n_fsrise + 1;
            fsrise_cyc <= cyc;
        end
        fs_prev <= failsafe;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: one call per complete pulse of w us
    int m_thr   = 0;
    bit m_armed = 1'b0;
    bit m_fs    = 1'b1;
    int m_cnt   = 0;

    task automatic model_pulse(input int w, output bit acc);
        int c;
        acc = (w >= MIN_US - GUARD_US) && (w <= MAX_US + GUARD_US);
        if (acc) begin
            c = (w < MIN_US) ? MIN_US : ((w > MAX_US) ? MAX_US : w);
            c = c - MIN_US;
            if (m_armed) begin
                m_thr = c;
            end else begin
                m_thr = 0;
                m_cnt = (c <= ARM_THR) ? m_cnt + 1 : 0;
                if (m_cnt >= ARM_CNT) m_armed = 1'b1;
            end
            m_fs = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_thr = 0; m_armed = 1'b0; m_fs = 1'b1; m_cnt = 0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".thr"}, thr, m_thr);
        chk({tag, ".armed"}, armed, m_armed);
        chk({tag, ".fs"}, failsafe, m_fs);
    endtask

    task automatic send_pulse(input int w_us, input string tag, output bit acc);
        int s0, e0, fall_c;
        s0 = n_strb;
        e0 = n_perr;
        pwm = 1'b1;
        repeat (w_us * T) @(negedge clk);
        pwm = 1'b0;
        fall_c = cyc;
        repeat ($urandom_range(10, 30) * T) @(negedge clk);
        model_pulse(w_us, acc);
        chk({tag, ".strb"}, n_strb - s0, acc);
        chk({tag, ".perr"}, n_perr - e0, !acc);
        if (acc) begin
            chk({tag, ".sthr"}, strb_thr, m_thr);
            chk({tag, ".sarm"}, strb_armed, m_armed);
            chk({tag, ".sfs"}, strb_fs, 0);
            chk({tag, ".lat"}, strb_cyc - fall_c, LAT);
        end
        chk_state(tag);
    endtask

    int t3_w[7] = '{1500, 2050, 2150, 900, 899, 2100, 2101};

    initial begin
        bit acc;
        bit prev_rej;
        int s0, e0, f0, sc, d, cat, w;

        pwm   = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst.thr", thr, 0);
        chk("rst.valid", thr_valid, 0);
        chk("rst.armed", armed, 0);
        chk("rst.fs", failsafe, 1);
        chk("rst.perr", perr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle line: failsafe stays, nothing strobes
        s0 = n_strb; e0 = n_perr;
        repeat ((TO_US + 100) * T) @(negedge clk);
        chk("idle.strb", n_strb - s0, 0);
        chk("idle.perr", n_perr - e0, 0);
        chk_state("idle");

        // Arming sequence
        for (int i = 0; i < 5; i++) send_pulse(1000, "arm", acc);

        // Armed mapping and band edges
        prev_rej = 1'b0;
        foreach (t3_w[i]) begin
            send_pulse(t3_w[i], "band", acc);
            prev_rej = !acc;
        end

        // Random pulses; never two rejects in a row so the timeout cannot expire here
        for (int i = 0; i < 3; i++) begin
            cat = (prev_rej || i == 2) ? 1 : int'($urandom_range(0, 3));
            case (cat)
                0:       w = int'($urandom_range(850, 899));
                3:       w = int'($urandom_range(2101, 2150));
                default: w = int'($urandom_range(900, 2100));
            endcase
            send_pulse(w, "rnd", acc);
            prev_rej = !acc;
        end

        // Signal loss
        sc = strb_cyc;
        f0 = n_fsrise;
        repeat ((TO_US + 100) * T) @(negedge clk);
        chk("to.rise", n_fsrise - f0, 1);
        d = fsrise_cyc - sc;
        chk("to.win", (d >= (TO_US - 1) * T) && (d <= (TO_US + 1) * T), 1);
        m_fs = 1'b1; m_armed = 1'b0; m_thr = 0; m_cnt = 0;
        chk_state("to");

        // High-throttle pulse breaks an arming run
        for (int i = 0; i < 3; i++) send_pulse(1000, "rearm", acc);
        send_pulse(1600, "break", acc);
        for (int i = 0; i < 4; i++) send_pulse(1000, "rearm2", acc);

        // Reset in the middle of a pulse
        s0 = n_strb; e0 = n_perr;
        pwm = 1'b1;
        repeat (700 * T) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.thr", thr, 0);
        chk("midrst.armed", armed, 0);
        chk("midrst.fs", failsafe, 1);
        rst_n = 1'b1;
        model_reset();
        repeat (800 * T) @(negedge clk);
        pwm = 1'b0;
        repeat (30 * T) @(negedge clk);
        chk("midrst.strb", n_strb - s0, 0);
        chk("midrst.perr", n_perr - e0, 0);
        send_pulse(1500, "postrst", acc);

        // Two-clock glitch
        s0 = n_strb; e0 = n_perr;
        pwm = 1'b1;
        repeat (2) @(negedge clk);
        pwm = 1'b0;
        repeat (30 * T) @(negedge clk);
        chk("glitch.perr", n_perr - e0, GLITCH_ERR);
        chk("glitch.strb", n_strb - s0, 0);
        chk_state("glitch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
